// File: rtl/mul_iter.sv
// Iterative shift-add multiplier for RV64M: MUL, MULH, MULHSU, MULHU, MULW.
// Optional early exit when the remaining multiplier bits are zero: define MUL_EARLY_EXIT_EN.
module mul_iter #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c
);

  localparam int K      = BITS_PER_CYCLE;
  localparam int N_FULL = WIDTH / K;
  localparam int N_WORD = 32 / K;
  localparam int CW     = $clog2(N_FULL + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } op_e;

  state_e             state, state_next;
  op_e                op_q;
  logic               neg_q;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   a_mag, b_rem;
  logic [2*WIDTH-1:0] acc;

  logic               accept, last;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_prep, b_prep;
  logic [K-1:0]       digit;
  logic [WIDTH+K-1:0] partial, sum;
  logic [2*WIDTH-1:0] acc_step, acc_next, prod, prod_s;
  logic [WIDTH-1:0]   result;

  assign accept = (state != BUSY) && start && (op <= 3'd4) && !flush;

  // Operand preparation: magnitudes plus the sign of the final product.
  assign sign_a = ((op == OP_MULH) || (op == OP_MULHSU)) && a[WIDTH-1];
  assign sign_b = (op == OP_MULH) && b[WIDTH-1];
  assign a_prep = (op == OP_MULW) ? {{(WIDTH-32){1'b0}}, a[31:0]} :
                  sign_a          ? -a : a;
  assign b_prep = (op == OP_MULW) ? {{(WIDTH-32){1'b0}}, b[31:0]} :
                  sign_b          ? -b : b;

  // One iteration: add a_mag * digit into the upper half, then shift right by K.
  assign digit    = b_rem[K-1:0];
  assign partial  = {{K{1'b0}}, a_mag} * {{WIDTH{1'b0}}, digit};
  assign sum      = {{K{1'b0}}, acc[2*WIDTH-1:WIDTH]} + partial;
  assign acc_step = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> K);

`ifdef MUL_EARLY_EXIT_EN
  // Skipped iterations would only shift, so apply all remaining shifts at once.
  assign acc_next = (b_rem == '0) ? (acc >> (int'(count) * K)) : acc_step;
  assign last     = (b_rem == '0) || (count == CW'(1));
`else
  assign acc_next = acc_step;
  assign last     = (count == CW'(1));
`endif

  // MULW runs only 32 iterations, leaving the product 32 bits higher up.
  assign prod   = (op_q == OP_MULW) ? (acc_next >> 32) : acc_next;
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    result = prod_s[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:  result = prod_s[WIDTH-1:0];
      OP_MULW: result = {{(WIDTH-32){prod_s[31]}}, prod_s[31:0]};
      default: result = prod_s[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = accept ? BUSY : IDLE;
      BUSY: begin
        if (flush)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: datapath registers are cleared too, so a reset mid-operation leaves no stale product.
      op_q  <= OP_MUL;
      neg_q <= 1'b0;
      count <= '0;
      a_mag <= '0;
      b_rem <= '0;
      acc   <= '0;
      c     <= '0;
    end else if (accept) begin
      op_q  <= op_e'(op);
      neg_q <= sign_a ^ sign_b;
      count <= (op == OP_MULW) ? CW'(N_WORD) : CW'(N_FULL);
      a_mag <= a_prep;
      b_rem <= b_prep;
      acc   <= '0;
    end else if ((state == BUSY) && !flush) begin
      acc   <= acc_next;
      b_rem <= b_rem >> K;
      count <= count - CW'(1);
      if (last) c <= result;
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Directed self-checking bench for mul_iter: results, latency, flush, async reset, boundaries.
module tb_mul_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [63:0] c;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3, MULW = 3'd4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  mul_iter #(.WIDTH(64), .BITS_PER_CYCLE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Expected done latency: full-length value, or the early-exit value when enabled.
  function automatic int lat(input int full, input int early);
`ifdef MUL_EARLY_EXIT_EN
    return early;
`else
    return full;
`endif
  endfunction

  // Wait (bounded) for done, counting cycles; lat_cnt is 1 on the first cycle checked.
  task automatic wait_done(output int lat_cnt);
    lat_cnt = 1;
    while (!done && lat_cnt < 300) begin
      @(negedge clk);
      lat_cnt++;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_c, input int exp_lat, input string tag);
    int l;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = MUL; a = '0; b = '0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(l);
    check({tag, "_lat"}, 64'(l), 64'(exp_lat));
    check({tag, "_c"}, c, exp_c);
  endtask

  initial begin
    int  l;
    bit  saw_done;
    reset = 1'b0; start = 1'b0; op = MUL; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_c", c, 64'd0);
    reset = 1'b1;

    // Basic MUL and result hold
    run_op(MUL, 64'd3, 64'd5, 64'd15, lat(65, 5), "mul_3x5");
    repeat (3) @(negedge clk);
    check("hold_c", c, 64'd15);
    check("hold_busy", 64'(busy), 64'd0);

    // Sign handling on all-ones operands
    run_op(MULHU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, lat(65, 65), "mulhu_ones");
    run_op(MULH,  ONES, ONES, 64'd0, lat(65, 3), "mulh_ones");
    run_op(MUL,   ONES, ONES, 64'd1, lat(65, 65), "mul_ones");

    // Mixed sign and most-negative operands
    run_op(MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, lat(65, 4), "mulhsu_m2x3");
    run_op(MULH, MINV, MINV, 64'h4000_0000_0000_0000, lat(65, 65), "mulh_minv");

    // Flush in BUSY cycle 10
    @(negedge clk);
    start = 1'b1; op = MUL; a = ONES; b = ONES;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_c10", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_c11", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_c_kept", c, 64'h4000_0000_0000_0000);
    run_op(MUL, 64'd6, 64'd7, 64'd42, lat(65, 5), "after_flush");

    // Flush in IDLE blocks acceptance; invalid op is ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MUL; a = 64'd2; b = 64'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_blocks", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b1; op = 3'd5;
    @(negedge clk);
    start = 1'b0; op = MUL;
    check("invalid_op_busy", 64'(busy), 64'd0);
    check("invalid_op_c", c, 64'd42);

    // MULW followed back-to-back by MUL with start held high
    @(negedge clk);
    start = 1'b1; op = MULW; a = 64'h7FFF_FFFF; b = 64'd2;
    @(posedge clk);
    @(negedge clk);
    op = MUL; a = 64'd6; b = 64'd7;
    wait_done(l);
    check("mulw_lat", 64'(l), 64'(lat(33, 4)));
    check("mulw_c", c, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check("b2b_no_gap", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(l);
    check("b2b_lat", 64'(l), 64'(lat(65, 5)));
    check("b2b_c", c, 64'd42);

    // Asynchronous reset in BUSY cycle 20
    @(negedge clk);
    start = 1'b1; op = MUL; a = ONES; b = ONES;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_c", c, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("arst_after_busy", 64'(busy), 64'd0);

    // Zero operands and short multipliers
    run_op(MUL, 64'd9, 64'd1, 64'd9, lat(65, 3), "mul_9x1");
    run_op(MUL, 64'd5, 64'd0, 64'd0, lat(65, 2), "mul_b0");
    run_op(MUL, 64'd0, 64'd7, 64'd0, lat(65, 5), "mul_a0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
